// File: rtl/hr_ascii_framer.sv
// Purpose: converts a 16-bit unsigned value to a decimal ASCII line and streams it one byte at a time, most significant digit first (build option HR_ASCII_FRAMER_PREFIX_EN adds an "HR=" prefix).
// Latency: the first byte is valid 17 cycles after the sample is accepted (16 double-dabble shifts plus 1 load cycle); after that, one byte per cycle while o_tready is high.
// Backpressure: o_tvalid/o_tdata/o_tlast hold while o_tready is low; i_ready is high only when idle, so no second sample is buffered.
module hr_ascii_framer #(
    parameter int EOL_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [15:0] i_value,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [7:0]  o_tdata,
    output logic        o_tkeep,
    output logic        o_tlast
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // Byte positions in a frame template. Positions that a frame does not
    // use are skipped: leading-zero digits, and CR in LF-only mode.
`ifdef HR_ASCII_FRAMER_PREFIX_EN
    localparam logic [3:0] POS_H  = 4'd0;
    localparam logic [3:0] POS_R  = 4'd1;
    localparam logic [3:0] POS_EQ = 4'd2;
`endif
    localparam logic [3:0] POS_D4 = 4'd3;
    localparam logic [3:0] POS_D3 = 4'd4;
    localparam logic [3:0] POS_D2 = 4'd5;
    localparam logic [3:0] POS_D1 = 4'd6;
    localparam logic [3:0] POS_D0 = 4'd7;
    localparam logic [3:0] POS_CR = 4'd8;
    localparam logic [3:0] POS_LF = 4'd9;

    state_t      state, state_nxt;
    logic [15:0] bin_q, bin_nxt;
    logic [19:0] bcd_q, bcd_nxt;
    logic [19:0] bcd_adj;
    logic [35:0] shifted;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [3:0]  pos_q, pos_nxt;
    logic [3:0]  first_pos;
    logic [3:0]  start_pos;
    logic [3:0]  pos_adv;
    logic        i_ready_nxt;
    logic        tvalid_nxt;
    logic        tlast_nxt;
    logic [7:0]  tdata_nxt;
    logic        accept;
    logic        out_fire;

    assign accept   = i_valid & i_ready;
    assign out_fire = o_tvalid & o_tready;
    assign o_tkeep  = 1'b1;

    // ASCII byte for a template position. A digit is 0x30 + BCD, and since
    // the BCD digit is at most 9 that is just {4'h3, digit}.
    function automatic logic [7:0] byte_at(input logic [3:0] p, input logic [19:0] b);
        logic [7:0] r;
        case (p)
`ifdef HR_ASCII_FRAMER_PREFIX_EN
            POS_H:   r = 8'h48;
            POS_R:   r = 8'h52;
            POS_EQ:  r = 8'h3D;
`endif
            POS_D4:  r = {4'h3, b[19:16]};
            POS_D3:  r = {4'h3, b[15:12]};
            POS_D2:  r = {4'h3, b[11:8]};
            POS_D1:  r = {4'h3, b[7:4]};
            POS_D0:  r = {4'h3, b[3:0]};
            POS_CR:  r = 8'h0D;
            POS_LF:  r = 8'h0A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // {bcd, binary} pair left by one bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < 5; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Leading-zero suppression: find the most significant non-zero digit.
    // If every digit is zero, the units digit is used so that value 0 prints "0".
    always_comb begin
        first_pos = POS_D0;
        for (int k = 0; k < 5; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                first_pos = 4'(7 - k);
            end
        end
`ifdef HR_ASCII_FRAMER_PREFIX_EN
        start_pos = POS_H;
`else
        start_pos = first_pos;
`endif
    end

    // Position that follows the byte now presented.
    always_comb begin
        pos_adv = pos_q + 4'd1;
        if (pos_q == POS_D0) begin
            pos_adv = (EOL_CRLF != 0) ? POS_CR : POS_LF;
        end
`ifdef HR_ASCII_FRAMER_PREFIX_EN
        if (pos_q == POS_EQ) begin
            pos_adv = first_pos;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_CONV;
            S_CONV: if (cnt_q == 4'd15) state_nxt = S_SEND;
            S_SEND: if (out_fire && o_tlast) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: next values for the datapath and the registered outputs.
    always_comb begin
        bin_nxt     = bin_q;
        bcd_nxt     = bcd_q;
        cnt_nxt     = cnt_q;
        pos_nxt     = pos_q;
        tvalid_nxt  = o_tvalid;
        tdata_nxt   = o_tdata;
        tlast_nxt   = o_tlast;
        i_ready_nxt = (state_nxt == S_IDLE);
        case (state)
            S_IDLE: begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
                if (accept) begin
                    bin_nxt = i_value;
                    bcd_nxt = 20'd0;
                    cnt_nxt = 4'd0;
                end
            end
            S_CONV: begin
                bcd_nxt = shifted[35:16];
                bin_nxt = shifted[15:0];
                cnt_nxt = cnt_q + 4'd1;
            end
            S_SEND: begin
                if (!o_tvalid) begin
                    // First cycle in S_SEND: load the first byte of the frame.
                    pos_nxt    = start_pos;
                    tdata_nxt  = byte_at(start_pos, bcd_q);
                    tlast_nxt  = 1'b0;
                    tvalid_nxt = 1'b1;
                end else if (out_fire) begin
                    if (o_tlast) begin
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                    end else begin
                        pos_nxt   = pos_adv;
                        tdata_nxt = byte_at(pos_adv, bcd_q);
                        tlast_nxt = (pos_adv == POS_LF);
                    end
                end
            end
            default: begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers. Reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_ready  <= 1'b0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= 8'h00;
            bin_q    <= 16'd0;
            bcd_q    <= 20'd0;
            cnt_q    <= 4'd0;
            pos_q    <= 4'd0;
        end else begin
            i_ready  <= i_ready_nxt;
            o_tvalid <= tvalid_nxt;
            o_tlast  <= tlast_nxt;
            o_tdata  <= tdata_nxt;
            bin_q    <= bin_nxt;
            bcd_q    <= bcd_nxt;
            cnt_q    <= cnt_nxt;
            pos_q    <= pos_nxt;
        end
    end

endmodule

// File: tb/tb_hr_ascii_framer.sv
// Purpose: two framer instances (CR LF and LF-only) checked against a decimal-string model.
// Latency: checks that the first byte appears 17 cycles after acceptance and that there are no gaps within a frame.
// Backpressure: drives random and directed o_tready stalls and checks that the held outputs stay stable.
module tb_hr_ascii_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  i_valid;
    logic [1:0]  i_ready;
    logic [15:0] i_value [2];
    logic [1:0]  o_tvalid;
    logic [1:0]  o_tready;
    logic [7:0]  o_tdata [2];
    logic [1:0]  o_tkeep;
    logic [1:0]  o_tlast;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       got_last[$];

    hr_ascii_framer #(.EOL_CRLF(1)) u_crlf (
        .clk(clk), .rst(rst[0]), .i_valid(i_valid[0]), .i_ready(i_ready[0]),
        .i_value(i_value[0]), .o_tvalid(o_tvalid[0]), .o_tready(o_tready[0]),
        .o_tdata(o_tdata[0]), .o_tkeep(o_tkeep[0]), .o_tlast(o_tlast[0])
    );

    hr_ascii_framer #(.EOL_CRLF(0)) u_lf (
        .clk(clk), .rst(rst[1]), .i_valid(i_valid[1]), .i_ready(i_ready[1]),
        .i_value(i_value[1]), .o_tvalid(o_tvalid[1]), .o_tready(o_tready[1]),
        .o_tdata(o_tdata[1]), .o_tkeep(o_tkeep[1]), .o_tlast(o_tlast[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame: the decimal string of the value, followed by the line terminator.
    task automatic build_exp(input int value, input bit crlf);
        string s;
        exp_q.delete();
`ifdef HR_ASCII_FRAMER_PREFIX_EN
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h3D);
`endif
        s = $sformatf("%0d", value);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int d, input int value);
        int w;
        int early;
        w = 0;
        early = 0;
        while (i_ready[d] !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        check("ready_before_sample", 32'(i_ready[d]), 32'd1);
        i_valid[d] = 1'b1;
        i_value[d] = 16'(value);
        step();
        // Observe the cycles after acceptance edges T0..T16 while driving noise on the input.
        for (int k = 0; k < 17; k++) begin
            if (o_tvalid[d] !== 1'b0) early++;
            if (i_ready[d] !== 1'b0) early++;
            i_valid[d]  = 1'($urandom % 2);
            i_value[d]  = 16'($urandom);
            o_tready[d] = 1'($urandom % 2);
            step();
        end
        i_valid[d] = 1'b0;
        check("quiet_during_conv", 32'(early), 32'd0);
        check("first_tvalid_at_17", 32'(o_tvalid[d]), 32'd1);
    endtask

    // mode 0: ready always high; 1: random ready; 2: three stall cycles on the second byte
    task automatic collect(input int d, input int mode, input int stop_after);
        int n;
        int iter;
        int stall;
        bit done;
        bit hold;
        bit fired_prev;
        logic [7:0] hd;
        logic hl;
        n = 0; iter = 0; stall = 0; done = 0; hold = 0; fired_prev = 0;
        hd = 8'h00; hl = 1'b0;
        got_q.delete();
        got_last.delete();
        while (!done && iter < 300) begin
            if (hold)
                check("hold_stable", 32'({o_tvalid[d], o_tlast[d], o_tdata[d]}), 32'({1'b1, hl, hd}));
            if (fired_prev)
                check("no_bubble", 32'(o_tvalid[d]), 32'd1);
            if (mode == 0) begin
                o_tready[d] = 1'b1;
            end else if (mode == 1) begin
                o_tready[d] = 1'(($urandom % 3) != 0);
            end else if (n == 1 && stall < 3 && o_tvalid[d] === 1'b1) begin
                o_tready[d] = 1'b0;
                stall++;
            end else begin
                o_tready[d] = 1'b1;
            end
            i_valid[d] = 1'($urandom % 2);
            i_value[d] = 16'($urandom);
            hold = (o_tvalid[d] === 1'b1) && !o_tready[d];
            hd = o_tdata[d];
            hl = o_tlast[d];
            fired_prev = 0;
            if (o_tvalid[d] === 1'b1 && o_tready[d]) begin
                got_q.push_back(o_tdata[d]);
                got_last.push_back(o_tlast[d]);
                n++;
                if (o_tlast[d] === 1'b1 || (stop_after != 0 && n == stop_after)) done = 1;
                else fired_prev = 1;
            end
            step();
            iter++;
        end
        i_valid[d]  = 1'b0;
        o_tready[d] = 1'b0;
        check("collect_done", 32'(done), 32'd1);
        if (mode == 2) check("stall_applied", 32'(stall), 32'd3);
    endtask

    task automatic run_frame(input int d, input int value, input int mode);
        int cnt;
        build_exp(value, d == 0);
        send_sample(d, value);
        collect(d, mode, 0);
        check("ready_after_last", 32'(i_ready[d]), 32'd1);
        check("idle_after_last", 32'(o_tvalid[d]), 32'd0);
        check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        cnt = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < cnt; i++) begin
            check($sformatf("byte[%0d] v=%0d", i, value), 32'(got_q[i]), 32'(exp_q[i]));
            check($sformatf("tlast[%0d] v=%0d", i, value), 32'(got_last[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int v;
        rst      = 2'b11;
        i_valid  = 2'b00;
        o_tready = 2'b00;
        i_value[0] = 16'd0;
        i_value[1] = 16'd0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_i_ready", 32'(i_ready[k]), 32'd0);
            check("rst_tvalid", 32'(o_tvalid[k]), 32'd0);
            check("rst_tlast", 32'(o_tlast[k]), 32'd0);
            check("rst_tdata", 32'(o_tdata[k]), 32'd0);
            check("rst_tkeep", 32'(o_tkeep[k]), 32'd1);
        end
        rst = 2'b00;
        step();
        check("ready_after_rst0", 32'(i_ready[0]), 32'd1);
        check("ready_after_rst1", 32'(i_ready[1]), 32'd1);

        // Directed frames
        run_frame(0, 72, 0);
        run_frame(0, 0, 0);
        run_frame(0, 65535, 0);
        run_frame(0, 100, 2);
        run_frame(1, 5, 0);
        run_frame(1, 0, 0);
        run_frame(1, 100, 2);

        // Reset in the middle of a frame, after two bytes of 65535
        build_exp(65535, 1);
        send_sample(0, 65535);
        collect(0, 0, 2);
        check("partial_len", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("partial_b0", 32'(got_q[0]), 32'(exp_q[0]));
            check("partial_b1", 32'(got_q[1]), 32'(exp_q[1]));
        end
        o_tready[0] = 1'b1;
        rst[0] = 1'b1;
        step();
        check("midrst_tvalid", 32'(o_tvalid[0]), 32'd0);
        check("midrst_tlast", 32'(o_tlast[0]), 32'd0);
        check("midrst_i_ready", 32'(i_ready[0]), 32'd0);
        check("midrst_tkeep", 32'(o_tkeep[0]), 32'd1);
        rst[0] = 1'b0;
        o_tready[0] = 1'b0;
        step();
        check("midrst_ready_after", 32'(i_ready[0]), 32'd1);
        check("midrst_no_tvalid", 32'(o_tvalid[0]), 32'd0);
        run_frame(0, 9, 0);

        // Random frames on both instances
        for (int r = 0; r < 24; r++) begin
            d = r % 2;
            v = (($urandom % 4) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
            run_frame(d, v, int'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
